meteor1_sprite_gen: RTL
=======================

Name: meteor1_sprite_gen

Overview:
- Generates per-pixel palette indices for one falling meteor sprite and feeds the Meteor1 4-bit palette-index-to-RGB lookup directly downstream.
- Holds meteor position and state, advances it once per frame, maps VGA DrawX/DrawY to a sprite-ROM address, and registers the ROM output into a pixel index plus an opaque flag.
- Sits between the VGA controller, the sprite ROM and the palette/colour mapper.

Parameters:
- SPRITE_W, 32, sprite width in pixels (power of two)
- SPRITE_H, 32, sprite height in pixels
- SCREEN_W, 640, visible width
- SCREEN_H, 480, visible height
- TRANSP_IDX, 1, palette index treated as transparent

Ports:
- Clk  in  1  pixel clock
- Reset_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse at vsync
- spawn  in  1  one-cycle request to launch a meteor
- spawn_x  in  10  launch column (left edge)
- speed  in  4  rows per frame
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- rom_addr  out  10  sprite ROM address, registered
- rom_q  in  4  sprite ROM data; synchronous ROM, valid 1 cycle after rom_addr
- pix_index  out  4  palette index to the palette block
- pix_on  out  1  meteor opaque at this pixel
- active  out  1  meteor in flight
- landed  out  1  one-cycle pulse when the meteor leaves the bottom of the screen

Behaviour:
- Reset (async, Reset_n=0):
  - State IDLE; pos_x, pos_y and vel = 0.
  - Pipeline regs cleared; rom_addr, pix_index, pix_on, active, landed all 0.
  - Reset mid-fall abandons the meteor with no landed pulse.
- FSM states are IDLE and FALL. active=1 iff state is FALL.
- IDLE transitions:
  - spawn=1: go to FALL.
  - pos_x = min(spawn_x, SCREEN_W-SPRITE_W).
  - pos_y = 0.
  - vel = speed, or 1 if speed=0.
  - If frame_start and spawn occur in the same cycle, spawn wins; no move that frame.
- FALL transitions:
  - spawn is ignored.
  - On frame_start, compute next = pos_y + vel in 11 bits.
  - If next >= SCREEN_H: go to IDLE, pulse landed=1 for exactly one cycle, pos_y unchanged.
  - Otherwise pos_y = next.
  - pos_x never changes during a fall.
- Hit test (combinational, stage 0):
  - dx = DrawX - pos_x and dy = DrawY - pos_y, both 11-bit signed.
  - hit = active && 0 <= dx < SPRITE_W && 0 <= dy < SPRITE_H.
- Pipeline, with DrawX/DrawY presented at cycle n:
  - n+1: rom_addr = dy*SPRITE_W + dx (low 10 bits) if hit, else 0; hit1 = hit.
  - n+2: rom_q is valid; hit2 = hit1.
  - n+3: pix_index = rom_q if hit2, else 0; pix_on = hit2 && (rom_q != TRANSP_IDX).
  - Fixed latency: 3 cycles DrawX/DrawY to pix_index/pix_on. Throughput is one pixel per cycle with no stalls.
- Position updates occur only on frame_start, so pixels already in the pipeline complete with the position sampled at stage 0.
- A sprite partly below row SCREEN_H-1 renders only visible rows; no vertical wrap. No horizontal wrap because spawn_x is clamped.

Test Plan:
- Reset: Reset_n=0 during FALL -> immediately active=0, pix_on=0, rom_addr=0, landed stays 0; after release, state IDLE.
- Spawn and render:
  - spawn_x=100, speed=4, then 3 frame_start pulses -> pos_y=12.
  - DrawX=100, DrawY=12 with rom_q=5 -> rom_addr=0 at n+1, pix_index=5 and pix_on=1 at n+3.
  - DrawX=131, DrawY=43 -> rom_addr=1023.
  - DrawX=132 -> rom_addr=0, pix_on=0, pix_index=0.
- Transparency: in-sprite pixel with rom_q=TRANSP_IDX=1 -> pix_index=1, pix_on=0. Same pixel with rom_q=0 -> pix_on=1, pix_index=0.
- Clamp and zero speed: spawn_x=630, speed=0 -> pos_x=608, vel=1; after 1 frame_start pos_y=1; DrawX=639 at row 1 is a hit with dx=31.
- Landing:
  - speed=15 -> pos_y=465 after the 31st frame_start.
  - 32nd frame_start -> landed=1 for one cycle, active=0.
  - A 33rd frame_start produces no further landed pulse.
- Simultaneous and ignored events:
  - spawn with frame_start in IDLE -> pos_y=0, active=1.
  - spawn_x=200 asserted during FALL -> pos_x unchanged, no restart.

Source files
------------

// File: rtl/meteor1_sprite_gen.sv
// Single falling-meteor sprite generator: holds position, advances it once per frame,
// and turns DrawX/DrawY into a registered sprite-ROM address and palette index (3-cycle latency).
module meteor1_sprite_gen #(
  parameter int SPRITE_W   = 32,
  parameter int SPRITE_H   = 32,
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int TRANSP_IDX = 1
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_start,
  input  logic       spawn,
  input  logic [9:0] spawn_x,
  input  logic [3:0] speed,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [9:0] rom_addr,
  input  logic [3:0] rom_q,
  output logic [3:0] pix_index,
  output logic       pix_on,
  output logic       active,
  output logic       landed
);

  typedef enum logic {IDLE, FALL} state_t;

  localparam logic [9:0]  MAX_X     = 10'(SCREEN_W - SPRITE_W);
  localparam logic [10:0] SCR_H11   = 11'(SCREEN_H);
  localparam logic [10:0] SPR_W11   = 11'(SPRITE_W);
  localparam logic [10:0] SPR_H11   = 11'(SPRITE_H);
  localparam logic [9:0]  SPR_W10   = 10'(SPRITE_W);
  localparam logic [3:0]  TRANSP    = 4'(TRANSP_IDX);

  state_t      state, state_nxt;
  logic [9:0]  pos_x, pos_x_nxt;
  logic [9:0]  pos_y, pos_y_nxt;
  logic [3:0]  vel, vel_nxt;
  logic        landed_nxt;
  logic [10:0] next_y;

  logic [10:0] dx, dy;
  logic        hit;
  logic [9:0]  addr_calc;
  logic        hit1, hit2;

  assign active = (state == FALL);

  // NOTE: every variable written in this block gets a default first, so no path
  // can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    pos_x_nxt  = pos_x;
    pos_y_nxt  = pos_y;
    vel_nxt    = vel;
    landed_nxt = 1'b0;
    next_y     = {1'b0, pos_y} + {7'd0, vel};
    unique case (state)
      IDLE: begin
        // spawn takes priority over a coincident frame_start: no move on the launch frame
        if (spawn) begin
          state_nxt = FALL;
          pos_x_nxt = (spawn_x > MAX_X) ? MAX_X : spawn_x;
          pos_y_nxt = '0;
          vel_nxt   = (speed == 4'd0) ? 4'd1 : speed;
        end
      end
      FALL: begin
        if (frame_start) begin
          if (next_y >= SCR_H11) begin
            state_nxt  = IDLE;
            landed_nxt = 1'b1;
          end else begin
            pos_y_nxt = next_y[9:0];
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= IDLE;
      pos_x  <= '0;
      pos_y  <= '0;
      vel    <= '0;
      landed <= 1'b0;
    end else begin
      state  <= state_nxt;
      pos_x  <= pos_x_nxt;
      pos_y  <= pos_y_nxt;
      vel    <= vel_nxt;
      landed <= landed_nxt;
    end
  end

  // Stage 0: signed offsets into the sprite; bit 10 is the sign.
  always_comb begin
    dx        = {1'b0, DrawX} - {1'b0, pos_x};
    dy        = {1'b0, DrawY} - {1'b0, pos_y};
    hit       = active && !dx[10] && (dx < SPR_W11) && !dy[10] && (dy < SPR_H11);
    addr_calc = dy[9:0] * SPR_W10 + dx[9:0];
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr  <= '0;
      hit1      <= 1'b0;
      hit2      <= 1'b0;
      pix_index <= '0;
      pix_on    <= 1'b0;
    end else begin
      rom_addr  <= hit ? addr_calc : '0;
      hit1      <= hit;
      // hit2 lines up with rom_q, which the ROM returns one cycle after rom_addr
      hit2      <= hit1;
      pix_index <= hit2 ? rom_q : '0;
      pix_on    <= hit2 && (rom_q != TRANSP);
    end
  end

endmodule
